// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: dual-issue scoreboard and issue controller for the
// SPU-Lite even/odd pipes. Tracks {valid, rt, unit idx} of every in-flight
// instruction per stage in both pipes. It grants issue only when all used
// sources are forwardable or already architectural. Otherwise it stalls
// decode in program order; the even slot is the older one.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   dec_valid_ep/op             decode slot valid
//   r{a,b,c,t}_addr_ep/op       source / destination registers
//   src_use_ep/op               operand-use mask {ra,rb,rc}
//   unit_idx_ep/op              producing unit code (0 = no register write)
//   flush                       branch-resolve kill
//   issue_ep/op, stall          issue grants and decode stall (combinational)
//   sb_idx_ep/op                per-stage unit code, 0 when the stage is invalid
//   sb_addr_ep/op               per-stage destination register
//   stall_cnt_ep/op             saturating stall counters (ISSUE_HAZARD_PERF_CNT_EN only)
//
// Optional feature macro: ISSUE_HAZARD_PERF_CNT_EN
module issue_hazard_ctrl #(
    parameter int unsigned DEPTH        = 7,
    parameter int unsigned FLUSH_STAGES = 3,
    parameter int unsigned CNT_WD       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid_ep,
    input  logic                  dec_valid_op,
    input  logic [6:0]            ra_addr_ep,
    input  logic [6:0]            rb_addr_ep,
    input  logic [6:0]            rc_addr_ep,
    input  logic [6:0]            rt_addr_ep,
    input  logic [6:0]            ra_addr_op,
    input  logic [6:0]            rb_addr_op,
    input  logic [6:0]            rc_addr_op,
    input  logic [6:0]            rt_addr_op,
    input  logic [2:0]            src_use_ep,
    input  logic [2:0]            src_use_op,
    input  logic [2:0]            unit_idx_ep,
    input  logic [2:0]            unit_idx_op,
    input  logic                  flush,
    output logic                  issue_ep,
    output logic                  issue_op,
    output logic                  stall,
`ifdef ISSUE_HAZARD_PERF_CNT_EN
    output logic [CNT_WD-1:0]     stall_cnt_ep,
    output logic [CNT_WD-1:0]     stall_cnt_op,
`endif
    output logic [3*DEPTH-1:0]    sb_idx_ep,
    output logic [3*DEPTH-1:0]    sb_idx_op,
    output logic [7*DEPTH-1:0]    sb_addr_ep,
    output logic [7*DEPTH-1:0]    sb_addr_op
);

    localparam int unsigned RW = 7;
    localparam int unsigned IW = 3;

    logic [DEPTH-1:0]         vld_ep_q, vld_ep_d, vld_op_q, vld_op_d;
    logic [DEPTH-1:0][RW-1:0] rt_ep_q, rt_ep_d, rt_op_q, rt_op_d;
    logic [DEPTH-1:0][IW-1:0] idx_ep_q, idx_ep_d, idx_op_q, idx_op_d;
    logic [DEPTH-1:0]         pend_ep, pend_op;
    logic                     hazard_ep, hazard_op, pair_dep;

    // Stage at which a unit's result becomes forwardable.
    function automatic int unsigned ready_stage(input logic [IW-1:0] idx);
        case (idx)
            3'd1:       ready_stage = 2;
            3'd2, 3'd4: ready_stage = 3;
            3'd5:       ready_stage = 4;
            3'd3, 3'd6: ready_stage = 6;
            3'd7:       ready_stage = 7;
            default:    ready_stage = 0;
        endcase
    endfunction

    // True if any not-yet-ready entry in either pipe writes register a.
    function automatic logic addr_busy(
        input logic [RW-1:0]            a,
        input logic [DEPTH-1:0]         pe,
        input logic [DEPTH-1:0][RW-1:0] re,
        input logic [DEPTH-1:0]         po,
        input logic [DEPTH-1:0][RW-1:0] ro
    );
        logic b;
        b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            b = b | (pe[i] && (re[i] == a)) | (po[i] && (ro[i] == a));
        end
        return b;
    endfunction

    // Per-stage "result not yet forwardable" flags; stage number is index+1.
    always_comb begin
        pend_ep = '0;
        pend_op = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_ep[i] = vld_ep_q[i] && ((i + 1) < ready_stage(idx_ep_q[i]));
            pend_op[i] = vld_op_q[i] && ((i + 1) < ready_stage(idx_op_q[i]));
        end
    end

    // Hazard detection and issue/stall decision.
    always_comb begin
        hazard_ep = (src_use_ep[2] && addr_busy(ra_addr_ep, pend_ep, rt_ep_q, pend_op, rt_op_q))
                 || (src_use_ep[1] && addr_busy(rb_addr_ep, pend_ep, rt_ep_q, pend_op, rt_op_q))
                 || (src_use_ep[0] && addr_busy(rc_addr_ep, pend_ep, rt_ep_q, pend_op, rt_op_q));
        hazard_op = (src_use_op[2] && addr_busy(ra_addr_op, pend_ep, rt_ep_q, pend_op, rt_op_q))
                 || (src_use_op[1] && addr_busy(rb_addr_op, pend_ep, rt_ep_q, pend_op, rt_op_q))
                 || (src_use_op[0] && addr_busy(rc_addr_op, pend_ep, rt_ep_q, pend_op, rt_op_q));
        // Odd must not read or overwrite the even slot's same-cycle result.
        pair_dep  = dec_valid_ep && (unit_idx_ep != 3'd0)
                 && ((src_use_op[2] && (ra_addr_op == rt_addr_ep))
                  || (src_use_op[1] && (rb_addr_op == rt_addr_ep))
                  || (src_use_op[0] && (rc_addr_op == rt_addr_ep))
                  || ((rt_addr_op == rt_addr_ep) && (unit_idx_op != 3'd0)));
        issue_ep  = rst && dec_valid_ep && !hazard_ep && !flush;
        issue_op  = rst && dec_valid_op && !hazard_op && !pair_dep && !flush
                 && (issue_ep || !dec_valid_ep);
        stall     = rst && ((dec_valid_ep && !issue_ep) || (dec_valid_op && !issue_op));
    end

    // Scoreboard shift; flush kills entries currently in stages 1..FLUSH_STAGES.
    always_comb begin
        vld_ep_d = '0;
        rt_ep_d  = '0;
        idx_ep_d = '0;
        vld_op_d = '0;
        rt_op_d  = '0;
        idx_op_d = '0;
        if (issue_ep && (unit_idx_ep != 3'd0)) begin
            vld_ep_d[0] = 1'b1;
            rt_ep_d[0]  = rt_addr_ep;
            idx_ep_d[0] = unit_idx_ep;
        end
        if (issue_op && (unit_idx_op != 3'd0)) begin
            vld_op_d[0] = 1'b1;
            rt_op_d[0]  = rt_addr_op;
            idx_op_d[0] = unit_idx_op;
        end
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (!(flush && (i <= FLUSH_STAGES))) begin
                vld_ep_d[i] = vld_ep_q[i-1];
                rt_ep_d[i]  = rt_ep_q[i-1];
                idx_ep_d[i] = idx_ep_q[i-1];
                vld_op_d[i] = vld_op_q[i-1];
                rt_op_d[i]  = rt_op_q[i-1];
                idx_op_d[i] = idx_op_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_ep_q <= '0;
            rt_ep_q  <= '0;
            idx_ep_q <= '0;
            vld_op_q <= '0;
            rt_op_q  <= '0;
            idx_op_q <= '0;
        end else begin
            vld_ep_q <= vld_ep_d;
            rt_ep_q  <= rt_ep_d;
            idx_ep_q <= idx_ep_d;
            vld_op_q <= vld_op_d;
            rt_op_q  <= rt_op_d;
            idx_op_q <= idx_op_d;
        end
    end

    // Flatten scoreboard onto the forwarding-qualification buses.
    always_comb begin
        sb_idx_ep  = '0;
        sb_idx_op  = '0;
        sb_addr_ep = rt_ep_q;
        sb_addr_op = rt_op_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sb_idx_ep[IW*i +: IW] = vld_ep_q[i] ? idx_ep_q[i] : 3'd0;
            sb_idx_op[IW*i +: IW] = vld_op_q[i] ? idx_op_q[i] : 3'd0;
        end
    end

`ifdef ISSUE_HAZARD_PERF_CNT_EN
    logic [CNT_WD-1:0] cnt_ep_q, cnt_ep_d, cnt_op_q, cnt_op_d;

    // Saturating counts of non-flush cycles in which a valid slot is held.
    always_comb begin
        cnt_ep_d = cnt_ep_q;
        cnt_op_d = cnt_op_q;
        if (dec_valid_ep && !issue_ep && !flush && (cnt_ep_q != '1)) begin
            cnt_ep_d = cnt_ep_q + CNT_WD'(1);
        end
        if (dec_valid_op && !issue_op && !flush && (cnt_op_q != '1)) begin
            cnt_op_d = cnt_op_q + CNT_WD'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_ep_q <= '0;
            cnt_op_q <= '0;
        end else begin
            cnt_ep_q <= cnt_ep_d;
            cnt_op_q <= cnt_op_d;
        end
    end

    assign stall_cnt_ep = cnt_ep_q;
    assign stall_cnt_op = cnt_op_q;
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed self-checking bench for issue_hazard_ctrl (DEPTH=7, FLUSH_STAGES=3).
module tb_issue_hazard_ctrl;

    localparam int unsigned DEPTH = 7;

    logic              clk;
    logic              rst;
    logic              dec_valid_ep, dec_valid_op;
    logic [6:0]        ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
    logic [6:0]        ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
    logic [2:0]        src_use_ep, src_use_op;
    logic [2:0]        unit_idx_ep, unit_idx_op;
    logic              flush;
    logic              issue_ep, issue_op, stall;
    logic [3*DEPTH-1:0] sb_idx_ep, sb_idx_op;
    logic [7*DEPTH-1:0] sb_addr_ep, sb_addr_op;
`ifdef ISSUE_HAZARD_PERF_CNT_EN
    logic [31:0]       stall_cnt_ep, stall_cnt_op;
`endif

    int n_cmp;
    int n_err;

    issue_hazard_ctrl #(.DEPTH(DEPTH), .FLUSH_STAGES(3), .CNT_WD(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid_ep (dec_valid_ep),
        .dec_valid_op (dec_valid_op),
        .ra_addr_ep   (ra_addr_ep),
        .rb_addr_ep   (rb_addr_ep),
        .rc_addr_ep   (rc_addr_ep),
        .rt_addr_ep   (rt_addr_ep),
        .ra_addr_op   (ra_addr_op),
        .rb_addr_op   (rb_addr_op),
        .rc_addr_op   (rc_addr_op),
        .rt_addr_op   (rt_addr_op),
        .src_use_ep   (src_use_ep),
        .src_use_op   (src_use_op),
        .unit_idx_ep  (unit_idx_ep),
        .unit_idx_op  (unit_idx_op),
        .flush        (flush),
        .issue_ep     (issue_ep),
        .issue_op     (issue_op),
        .stall        (stall),
`ifdef ISSUE_HAZARD_PERF_CNT_EN
        .stall_cnt_ep (stall_cnt_ep),
        .stall_cnt_op (stall_cnt_op),
`endif
        .sb_idx_ep    (sb_idx_ep),
        .sb_idx_op    (sb_idx_op),
        .sb_addr_ep   (sb_addr_ep),
        .sb_addr_op   (sb_addr_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid_ep = 1'b0; dec_valid_op = 1'b0;
        ra_addr_ep = '0; rb_addr_ep = '0; rc_addr_ep = '0; rt_addr_ep = '0;
        ra_addr_op = '0; rb_addr_op = '0; rc_addr_op = '0; rt_addr_op = '0;
        src_use_ep = '0; src_use_op = '0; unit_idx_ep = '0; unit_idx_op = '0;
        flush = 1'b0;
    endtask

    task automatic drive_ep(input logic v, input logic [6:0] ra, input logic [6:0] rb,
                            input logic [6:0] rc, input logic [6:0] rt,
                            input logic [2:0] use_m, input logic [2:0] idx);
        dec_valid_ep = v; ra_addr_ep = ra; rb_addr_ep = rb; rc_addr_ep = rc;
        rt_addr_ep = rt; src_use_ep = use_m; unit_idx_ep = idx;
    endtask

    task automatic drive_op(input logic v, input logic [6:0] ra, input logic [6:0] rb,
                            input logic [6:0] rc, input logic [6:0] rt,
                            input logic [2:0] use_m, input logic [2:0] idx);
        dec_valid_op = v; ra_addr_op = ra; rb_addr_op = rb; rc_addr_op = rc;
        rt_addr_op = rt; src_use_op = use_m; unit_idx_op = idx;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 1) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        idle();

        // Outputs held at zero while in reset, even with a valid slot.
        drive_ep(1'b1, 7'd5, 7'd0, 7'd0, 7'd6, 3'b100, 3'd1);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_issue_ep", 64'(issue_ep), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_sb_idx_ep", 64'(sb_idx_ep), 64'(0));
        chk("rst_sb_addr_op", 64'(sb_addr_op), 64'(0));
        rst = 1'b1;
        idle();
        tick();

        // Long-latency RAW: idx 3 ready at stage 6.
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd5, 3'b000, 3'd3);
        #1;
        chk("lat_prod_issue", 64'(issue_ep), 64'(1));
        tick();
        drive_ep(1'b1, 7'd5, 7'd0, 7'd0, 7'd6, 3'b100, 3'd1);
        #1;
        chk("lat_sb_addr_s1", 64'(sb_addr_ep[6:0]), 64'(5));
        chk("lat_sb_idx_s1", 64'(sb_idx_ep[2:0]), 64'(3));
        for (int k = 0; k < 5; k++) begin
            if (k > 0) #1;
            chk("lat_stall", 64'(stall), 64'(1));
            chk("lat_hold_ep", 64'(issue_ep), 64'(0));
            tick();
        end
        #1;
        chk("lat_issue_t6", 64'(issue_ep), 64'(1));
        chk("lat_nostall_t6", 64'(stall), 64'(0));
        chk("lat_sb_idx_s6", 64'(sb_idx_ep[17:15]), 64'(3));
        tick();
        idle();
`ifdef ISSUE_HAZARD_PERF_CNT_EN
        chk("perf_cnt_ep", 64'(stall_cnt_ep), 64'(5));
        chk("perf_cnt_op", 64'(stall_cnt_op), 64'(0));
`endif
        drain();

        // Intra-pair RAW: odd reads even's same-cycle result.
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd10, 3'b000, 3'd1);
        drive_op(1'b1, 7'd10, 7'd0, 7'd0, 7'd11, 3'b100, 3'd2);
        #1;
        chk("pair_issue_ep", 64'(issue_ep), 64'(1));
        chk("pair_issue_op", 64'(issue_op), 64'(0));
        chk("pair_stall", 64'(stall), 64'(1));
        tick();
        dec_valid_ep = 1'b0;
        #1;
        chk("pair_op_t1", 64'(issue_op), 64'(0));
        chk("pair_stall_t1", 64'(stall), 64'(1));
        tick();
        #1;
        chk("pair_op_t2", 64'(issue_op), 64'(1));
        chk("pair_stall_t2", 64'(stall), 64'(0));
        drain();

        // Independent dual issue on an empty scoreboard.
        drive_ep(1'b1, 7'd1, 7'd2, 7'd0, 7'd3, 3'b110, 3'd2);
        drive_op(1'b1, 7'd20, 7'd0, 7'd0, 7'd4, 3'b100, 3'd1);
        #1;
        chk("dual_issue_ep", 64'(issue_ep), 64'(1));
        chk("dual_issue_op", 64'(issue_op), 64'(1));
        chk("dual_stall", 64'(stall), 64'(0));
        tick();
        idle();
        #1;
        chk("dual_sb_addr_ep", 64'(sb_addr_ep[6:0]), 64'(3));
        chk("dual_sb_idx_ep", 64'(sb_idx_ep[2:0]), 64'(2));
        chk("dual_sb_addr_op", 64'(sb_addr_op[6:0]), 64'(4));
        chk("dual_sb_idx_op", 64'(sb_idx_op[2:0]), 64'(1));
        drain();

        // Intra-pair WAW, and its qualification by unit codes.
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd12, 3'b000, 3'd1);
        drive_op(1'b1, 7'd0, 7'd0, 7'd0, 7'd12, 3'b000, 3'd1);
        #1;
        chk("waw_issue_ep", 64'(issue_ep), 64'(1));
        chk("waw_issue_op", 64'(issue_op), 64'(0));
        unit_idx_op = 3'd0;
        #1;
        chk("waw_op_nowrite", 64'(issue_op), 64'(1));
        unit_idx_op = 3'd1;
        unit_idx_ep = 3'd0;
        #1;
        chk("waw_ep_nowrite", 64'(issue_op), 64'(1));
        tick();
        // Even reads r12, written by the odd pipe at stage 1 (idx 1).
        drive_ep(1'b1, 7'd12, 7'd0, 7'd0, 7'd13, 3'b100, 3'd1);
        dec_valid_op = 1'b0;
        #1;
        chk("xpipe_hazard", 64'(issue_ep), 64'(0));
        drain();

        // Unit code 0 leaves no entry: reader issues the next cycle.
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd30, 3'b000, 3'd0);
        tick();
        drive_ep(1'b1, 7'd30, 7'd0, 7'd0, 7'd31, 3'b100, 3'd1);
        #1;
        chk("idx0_no_entry", 64'(issue_ep), 64'(1));
        drain();

        // Program order: held even slot blocks an independent odd.
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd15, 3'b000, 3'd7);
        tick();
        drive_ep(1'b1, 7'd0, 7'd15, 7'd0, 7'd16, 3'b010, 3'd1);
        drive_op(1'b1, 7'd0, 7'd0, 7'd0, 7'd17, 3'b000, 3'd1);
        #1;
        chk("order_ep", 64'(issue_ep), 64'(0));
        chk("order_op", 64'(issue_op), 64'(0));
        chk("order_stall", 64'(stall), 64'(1));
        drain();

        // Flush: stage-2 producer killed, stage-4 entry survives.
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd7, 3'b000, 3'd7);
        tick();
        idle();
        tick();
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd8, 3'b000, 3'd3);
        tick();
        idle();
        tick();
        drive_ep(1'b1, 7'd8, 7'd0, 7'd0, 7'd13, 3'b100, 3'd1);
        flush = 1'b1;
        #1;
        chk("fl_sb_before", 64'(sb_idx_ep), 64'(3608));
        chk("fl_issue_ep", 64'(issue_ep), 64'(0));
        chk("fl_stall", 64'(stall), 64'(1));
        tick();
        flush = 1'b0;
        #1;
        chk("fl_dep_issue", 64'(issue_ep), 64'(1));
        chk("fl_sb_after", 64'(sb_idx_ep), 64'(28672));
        chk("fl_deep_addr", 64'(sb_addr_ep[34:28]), 64'(7));
        drain();

        // Mid-run reset with r9 in flight in both pipes.
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd9, 3'b000, 3'd7);
        tick();
        idle();
        drive_op(1'b1, 7'd0, 7'd0, 7'd0, 7'd9, 3'b000, 3'd7);
        tick();
        idle();
        drive_ep(1'b1, 7'd0, 7'd0, 7'd0, 7'd9, 3'b000, 3'd7);
        tick();
        idle();
        drive_op(1'b1, 7'd0, 7'd0, 7'd0, 7'd9, 3'b000, 3'd7);
        tick();
        idle();
        #1;
        chk("mr_pre_idx_ep", 64'(sb_idx_ep), 64'(3640));
        chk("mr_pre_idx_op", 64'(sb_idx_op), 64'(455));
        rst = 1'b0;
        #1;
        chk("mr_idx_ep", 64'(sb_idx_ep), 64'(0));
        chk("mr_idx_op", 64'(sb_idx_op), 64'(0));
        chk("mr_addr_ep", 64'(sb_addr_ep), 64'(0));
        drive_ep(1'b1, 7'd9, 7'd0, 7'd0, 7'd20, 3'b100, 3'd1);
        #1;
        chk("mr_issue_in_rst", 64'(issue_ep), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mr_issue_after", 64'(issue_ep), 64'(1));
        chk("mr_stall_after", 64'(stall), 64'(0));
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
- Dual-issue scoreboard and issue controller for the SPU-Lite even/odd pipes. Sits between decode and the operand-forwarding network.
- Tracks the destination register and unit latency of every in-flight instruction, stage by stage, in both pipes.
- Grants issue only when every source operand is forwardable or already in the register file. Otherwise stalls decode in program order (even slot is older).

Parameters:
- DEPTH, 7, number of tracked pipeline stages per pipe (stages 1..DEPTH).
- FLUSH_STAGES, 3, stages 1..FLUSH_STAGES are killed by flush.
- CNT_WD, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- dec_valid_ep / dec_valid_op  in  1  even/odd decode slot holds an instruction.
- ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep  in  7  even source/destination registers.
- ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op  in  7  odd source/destination registers.
- src_use_ep / src_use_op  in  3  operand-use mask {ra,rb,rc}.
- unit_idx_ep / unit_idx_op  in  3  producing unit code; 0 = no register write.
- flush  in  1  branch-resolve kill.
- issue_ep / issue_op  out  1  the slot issues this cycle.
- stall  out  1  at least one valid slot is held.
- sb_idx_ep / sb_idx_op  out  3*DEPTH  per-stage unit code (0 when invalid); drives forwarding qualification.
- sb_addr_ep / sb_addr_op  out  7*DEPTH  per-stage destination register.

Behaviour:
- Reset: all scoreboard entries invalid; every output is 0 while rst is low, and the block is clean after release.
- Entry format: {valid, rt[6:0], idx[2:0]}. Each pipe is a DEPTH-deep shift register that advances every cycle and never stalls.
- Stage-1 load: stage 1 takes the issued instruction when issue && unit_idx != 0; otherwise it takes a bubble. An entry leaves after stage DEPTH; its result is then in the register file.
- Ready stage L by unit code:
  - 1 -> 2
  - 2, 4 -> 3
  - 5 -> 4
  - 3, 6 -> 6
  - 7 -> 7
- RAW hazard: a used source A is hazarded if any valid entry in either pipe at stage s has rt == A and s < L. Any unready match hazards the operand, even when an older ready match also exists.
- Even slot: issue_ep = dec_valid_ep && !hazard_ep && !flush.
- Odd slot: issue_op = dec_valid_op && !hazard_op && !flush && (issue_ep || !dec_valid_ep). It is also blocked by an intra-pair dependence when dec_valid_ep, the even unit code != 0, and either:
  - a used odd source equals rt_addr_ep (RAW), or
  - rt_addr_op == rt_addr_ep with the odd unit code != 0 (WAW).
- Intra-pair result: even issues, odd is held and re-evaluated next cycle against the updated scoreboard.
- stall = (dec_valid_ep && !issue_ep) || (dec_valid_op && !issue_op). It is combinational from the current-cycle inputs and state.
- Decode holds its slot contents while stalled. This block does not latch decode inputs.
- Flush: the same cycle forces issue_* = 0. On the next edge, entries in stages 1..FLUSH_STAGES in both pipes shift in as invalid; deeper entries continue normally.
- Reset asserted mid-operation clears all entries asynchronously, with no partial shift.

Optional Feature:
- Macro ISSUE_HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cnt_ep and stall_cnt_op (CNT_WD each).
  - stall_cnt_ep counts cycles with dec_valid_ep && !issue_ep && !flush.
  - stall_cnt_op counts cycles with dec_valid_op && !issue_op && !flush.
  - Both saturate at all-ones and reset to 0.
- When undefined, neither port nor counter logic exists, and the rest of the behaviour is identical.

Test Plan:
- Long-latency RAW: cycle t, even issues rt=5, idx=3. From t+1, even reads ra=5 -> stall=1 for t+1..t+5; issue_ep=1 at t+6, when the producer is at stage 6.
- Intra-pair RAW: even rt=10 idx=1 and odd ra=10 in the same cycle t -> issue_ep=1, issue_op=0; stall at t+1 (producer stage 1 < 2); issue_op=1 at t+2.
- Independent dual issue: even rt=3 reads r1,r2; odd rt=4 reads r20; scoreboard empty -> issue_ep=issue_op=1, stall=0; sb_addr_ep stage1=3 next cycle.
- Flush: producer rt=8 idx=3 at stage 2, dependent even reads r8, flush pulsed one cycle -> issue_ep=0 during flush; the entry is gone and the dependent issues the following cycle.
- Reset mid-run: rt=9 at stages 1..4 in both pipes, rst low for 2 cycles -> all sb_idx_* = 0 immediately; a consumer of r9 issues on the first cycle after release.
- With ISSUE_HAZARD_PERF_CNT_EN: the first scenario yields stall_cnt_ep=5 and stall_cnt_op=0.
